// File: rtl/sfi_pkg.sv
// Shared definitions for the SFI response path: FSM state encoding,
// default sandbox window and the field layout of a 64-bit request word.
package sfi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] SBX_BASE_DEF = 32'hA219_0000;
  localparam logic [31:0] SBX_MASK_DEF = 32'hFFFF_0000;

  // Request word layout: effective address in the upper half, payload below.
  localparam int unsigned ADDR_MSB = 63;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned DATA_MSB = 31;
  localparam int unsigned DATA_LSB = 0;

  // True when the address falls inside the masked sandbox window.
  function automatic logic in_sandbox(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/sfi_fifo.sv
// Accepted-request FIFO: power-of-two depth, pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module sfi_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards any queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sfi_resp.sv
// SFI response stage: accepts filtered request words, drops and counts the
// rejected (all-zero) ones, queues good words and forwards them to memory.
// Optional feature macro: SFI_RECHECK_EN re-validates the address against
// the sandbox window and treats out-of-window words as faults as well.
module sfi_resp
  import sfi_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] SBX_BASE    = SBX_BASE_DEF,
  parameter logic [31:0] SBX_MASK    = SBX_MASK_DEF,
  parameter int unsigned FAULT_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [63:0] req_data,
  output logic        req_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        fault_irq,
  output logic [15:0] fault_count,
  input  logic        fault_clr
);

  state_t      state;
  logic        fifo_full;
  logic        fifo_empty;
  logic [63:0] head;
  logic        req_xfer;
  logic        word_zero;
  logic        sbx_hit;
  logic        bad_word;
  logic        fault;
  logic        push;
  logic        pop;
  logic [15:0] count_inc;

  assign req_ready = (state == RUN) && !fifo_full;
  assign req_xfer  = req_valid && req_ready;
  assign word_zero = (req_data == '0);
  assign sbx_hit   = in_sandbox(req_data[ADDR_MSB:ADDR_LSB], SBX_BASE, SBX_MASK);

`ifdef SFI_RECHECK_EN
  assign bad_word = word_zero || !sbx_hit;
`else
  logic unused_sbx_hit;
  assign unused_sbx_hit = sbx_hit;
  assign bad_word       = word_zero;
`endif

  assign fault = req_xfer && bad_word;
  assign push  = req_xfer && !bad_word;
  assign pop   = mem_valid && mem_ready;

  assign mem_valid = !fifo_empty;
  // Gated so the memory side shows zeros whenever nothing is queued.
  assign mem_addr  = mem_valid ? head[ADDR_MSB:ADDR_LSB] : '0;
  assign mem_wdata = mem_valid ? head[DATA_MSB:DATA_LSB] : '0;

  assign count_inc = (fault_count == 16'hFFFF) ? fault_count : fault_count + 16'd1;

  sfi_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (req_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fault bookkeeping; a clear wins over a coincident fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_count <= '0;
      fault_irq   <= 1'b0;
    end else if (fault_clr) begin
      fault_count <= '0;
      fault_irq   <= 1'b0;
    end else if (fault) begin
      fault_count <= count_inc;
      fault_irq   <= 1'b1;
    end
  end

  // Control FSM: lock out new requests once the fault limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    state <= RUN;
        RUN:     if (!fault_clr && fault && (32'(count_inc) >= FAULT_LIMIT)) state <= LOCKED;
        LOCKED:  if (fault_clr) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfi_resp.sv
// Directed self-checking bench for sfi_resp (default parameters).
module tb_sfi_resp;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_data;
  logic        req_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        fault_irq;
  logic [15:0] fault_count;
  logic        fault_clr;

  int n_assert;
  int n_fail;

  logic [63:0] words [5];

  sfi_resp #(
    .DEPTH       (4),
    .SBX_BASE    (32'hA219_0000),
    .SBX_MASK    (32'hFFFF_0000),
    .FAULT_LIMIT (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .fault_irq   (fault_irq),
    .fault_count (fault_count),
    .fault_clr   (fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    mem_ready = 1'b0;
    fault_clr = 1'b0;
    for (int i = 0; i < 5; i++)
      words[i] = {32'hA219_0010 + 32'(i), 32'h0000_1000 + 32'(i)};

    // Reset state
    #1;
    chk("rst_req_ready",  req_ready,   0);
    chk("rst_mem_valid",  mem_valid,   0);
    chk("rst_mem_addr",   mem_addr,    0);
    chk("rst_mem_wdata",  mem_wdata,   0);
    chk("rst_fault_irq",  fault_irq,   0);
    chk("rst_fault_cnt",  fault_count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", req_ready, 0);
    tick();
    chk("run_req_ready",  req_ready, 1);

    // Good request, one-cycle latency
    mem_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 64'hA219_9872_0000_0000;
    tick();
    req_valid = 1'b0;
    chk("good_mem_valid", mem_valid,   1);
    chk("good_mem_addr",  mem_addr,    32'hA219_9872);
    chk("good_mem_wdata", mem_wdata,   0);
    chk("good_fault_cnt", fault_count, 0);
    tick();
    chk("good_drained",   mem_valid,   0);

    // Rejected word then clear
    req_valid = 1'b1;
    req_data  = 64'h0;
    tick();
    req_valid = 1'b0;
    chk("rej_mem_valid",  mem_valid,   0);
    chk("rej_fault_cnt",  fault_count, 1);
    chk("rej_fault_irq",  fault_irq,   1);
    chk("rej_req_ready",  req_ready,   1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault_cnt",  fault_count, 0);
    chk("clr_fault_irq",  fault_irq,   0);

    // Out-of-sandbox word
    req_valid = 1'b1;
    req_data  = 64'hBAD0_ADD0_1234_5678;
    tick();
    req_valid = 1'b0;
`ifdef SFI_RECHECK_EN
    chk("sbx_mem_valid",  mem_valid,   0);
    chk("sbx_fault_cnt",  fault_count, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("sbx_clr_cnt",    fault_count, 0);
`else
    chk("sbx_mem_valid",  mem_valid,   1);
    chk("sbx_mem_addr",   mem_addr,    32'hBAD0_ADD0);
    chk("sbx_mem_wdata",  mem_wdata,   32'h1234_5678);
    chk("sbx_fault_cnt",  fault_count, 0);
    tick();
    chk("sbx_drained",    mem_valid,   0);
`endif

    // Backpressure: 5 offered, 4 accepted
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_data  = words[i];
      chk($sformatf("bp_ready_%0d", i), req_ready, (i < 4) ? 1 : 0);
      tick();
    end
    req_valid = 1'b0;
    chk("bp_full_ready",  req_ready, 0);
    chk("bp_head_addr",   mem_addr,  words[0][63:32]);
    tick();
    chk("bp_stable_addr", mem_addr,  words[0][63:32]);
    chk("bp_stable_data", mem_wdata, words[0][31:0]);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_out_valid_%0d", i), mem_valid, 1);
      chk($sformatf("bp_out_addr_%0d", i),  mem_addr,  words[i][63:32]);
      chk($sformatf("bp_out_data_%0d", i),  mem_wdata, words[i][31:0]);
      tick();
    end
    chk("bp_empty",       mem_valid,   0);
    chk("bp_ready_again", req_ready,   1);
    chk("bp_fault_cnt",   fault_count, 0);

    // Lockout after three faults, queued word still drains
    mem_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = words[2];
    tick();
    req_data  = 64'h0;
    tick();
    tick();
    chk("lk_pre_ready",   req_ready,   1);
    chk("lk_pre_cnt",     fault_count, 2);
    tick();
    chk("lk_ready",       req_ready,   0);
    chk("lk_fault_cnt",   fault_count, 3);
    chk("lk_fault_irq",   fault_irq,   1);
    req_data  = words[4];
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    chk("lk_drain_valid", mem_valid,   1);
    chk("lk_drain_addr",  mem_addr,    words[2][63:32]);
    tick();
    chk("lk_no_push",     mem_valid,   0);
    chk("lk_still_lock",  req_ready,   0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("lk_clr_ready",   req_ready,   1);
    chk("lk_clr_cnt",     fault_count, 0);
    chk("lk_clr_irq",     fault_irq,   0);

    // Reset with two words queued
    mem_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = 64'h0;
    tick();
    req_data  = words[0];
    tick();
    req_data  = words[1];
    tick();
    req_valid = 1'b0;
    chk("mr_valid_pre",   mem_valid,   1);
    chk("mr_cnt_pre",     fault_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_async", mem_valid,   0);
    chk("mr_ready_async", req_ready,   0);
    chk("mr_addr_async",  mem_addr,    0);
    chk("mr_cnt_async",   fault_count, 0);
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_post_valid",  mem_valid,   0);
    chk("mr_post_cnt",    fault_count, 0);
    chk("mr_post_ready",  req_ready,   1);
    tick();
    chk("mr_post_empty",  mem_valid,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
